// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional tx_busy start timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t                  state;
  logic [IDW-1:0]          rr_ptr;
  logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

  logic                    found;
  logic [IDW-1:0]          winner;
  logic [NUM_REQ-1:0]      win_onehot;
  logic [DATA_WIDTH-1:0]   win_data;
  int unsigned             cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    win_onehot = '0;
    win_data   = '0;
    cand       = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[IDW'(cand)]) begin
        found                   = 1'b1;
        winner                  = IDW'(cand);
        win_onehot[IDW'(cand)]  = 1'b1;
        win_data                = req_bytes[IDW'(cand)];
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Outputs are registered one state ahead so ready/valid are high exactly during LOAD.
  always_ff @(posedge UCLK) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
      tx_data       <= '0;
      grant_id      <= '0;
      arb_busy      <= 1'b0;
      rr_ptr        <= IDW'(NUM_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt        <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found && !tx_busy) begin
            tx_data       <= win_data;
            grant_id      <= winner;
            req_ready     <= win_onehot;
            tx_data_valid <= 1'b1;
            arb_busy      <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          rr_ptr <= grant_id;
          state  <= WAIT_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        WAIT_START: begin
          if (tx_busy) state <= WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state    <= IDLE;
            arb_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8).
module tb_uart_tx_arbiter;

  logic        UCLK = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_busy;
  logic        tx_data_valid;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 UCLK = ~UCLK;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .UCLK          (UCLK),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .grant_id      (grant_id),
    .arb_busy      (arb_busy),
    .timeout_err   (timeout_err)
  );

  task automatic tick;
    @(negedge UCLK);
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    req_valid = '0;
    tx_busy   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Ticks until a grant appears; cycles = -1 if none within the budget.
  task automatic wait_load(input int max_cycles, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      tick();
      if (req_ready != '0 || tx_data_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Called in the LOAD cycle: raises tx_busy in WAIT_START, drops it, ends in IDLE.
  task automatic finish_frame(input int busy_len, output int stray);
    stray = 0;
    tick();
    if (req_ready != '0 || tx_data_valid) stray++;
    tx_busy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      tick();
      if (req_ready != '0 || tx_data_valid) stray++;
    end
    tx_busy = 1'b0;
    tick();
    if (req_ready != '0 || tx_data_valid) stray++;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp %b", req_ready, 4'b0000); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_data_valid got %b exp 0", tx_data_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_busy got %b exp 0", arb_busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    int cyc;
    int stray;
    req_data  = 32'h000000A5;
    req_valid = 4'b0001;
    wait_load(10, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", cyc); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    checks++; if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", tx_data_valid); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant got %0d exp 0", grant_id); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL single_arb_busy got %b exp 1", arb_busy); end
    req_valid = '0;
    finish_frame(11, stray);
    checks++; if (stray !== 0) begin errors++; $display("FAIL single_pulse_width got %0d extra pulses exp 0", stray); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL single_arb_idle got %b exp 0", arb_busy); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold got %h exp a5", tx_data); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_id [5];
    logic [7:0] exp_b  [5];
    int cyc;
    int stray;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_b  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    do_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_load(10, cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL rr_gap[%0d] got %0d exp 1", f, cyc); end
      checks++; if (grant_id !== exp_id[f]) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", f, grant_id, exp_id[f]); end
      checks++; if (req_ready !== (4'b0001 << exp_id[f]) || tx_data_valid !== 1'b1) begin
        errors++; $display("FAIL rr_ready[%0d] got %b/%b exp %b/1", f, req_ready, tx_data_valid, 4'b0001 << exp_id[f]);
      end
      checks++; if (tx_data !== exp_b[f]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", f, tx_data, exp_b[f]); end
      if (f == 4) req_valid = '0;
      finish_frame(4, stray);
      checks++; if (stray !== 0) begin errors++; $display("FAIL rr_one_per_window[%0d] got %0d extra exp 0", f, stray); end
    end
  endtask

  task automatic test_wrap;
    int cyc;
    int stray;
    req_valid = 4'b0100;
    wait_load(10, cyc);
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL wrap_setup got %0d exp 2", grant_id); end
    req_valid = '0;
    finish_frame(3, stray);
    req_valid = 4'b0011;
    wait_load(10, cyc);
    checks++; if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_first got %0d/%b exp 0/0001", grant_id, req_ready);
    end
    checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL wrap_first_data got %h exp 11", tx_data); end
    req_valid = 4'b0010;
    finish_frame(3, stray);
    wait_load(10, cyc);
    checks++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_second got %0d/%b exp 1/0010", grant_id, req_ready);
    end
    req_valid = '0;
    finish_frame(3, stray);
  endtask

  task automatic test_busy_hold;
    int viol;
    int stray;
    viol      = 0;
    tx_busy   = 1'b1;
    req_valid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req_ready != '0 || tx_data_valid || arb_busy) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL busy_hold got %0d grant cycles exp 0", viol); end
    tx_busy = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0100 || grant_id !== 2'd2 || tx_data_valid !== 1'b1) begin
      errors++; $display("FAIL busy_release got %b/%0d/%b exp 0100/2/1", req_ready, grant_id, tx_data_valid);
    end
    req_valid = '0;
    finish_frame(3, stray);
  endtask

  task automatic test_reset_mid_frame;
    int cyc;
    int stray;
    req_valid = 4'b1000;
    wait_load(10, cyc);
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL midrst_setup got %0d exp 3", grant_id); end
    req_valid = 4'b0110;
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    reset   = 1'b1;
    tx_busy = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0000 || tx_data_valid !== 1'b0 || tx_data !== 8'h00 ||
                  grant_id !== 2'd0 || arb_busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b v=%b d=%h g=%0d ab=%b te=%b exp all zero",
               req_ready, tx_data_valid, tx_data, grant_id, arb_busy, timeout_err);
    end
    reset = 1'b0;
    wait_load(10, cyc);
    checks++; if (cyc !== 1 || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL midrst_regrant got cyc=%0d g=%0d rdy=%b exp 1/1/0010", cyc, grant_id, req_ready);
    end
    req_valid = 4'b0100;
    finish_frame(3, stray);
    wait_load(10, cyc);
    checks++; if (grant_id !== 2'd2 || tx_data !== 8'h33) begin
      errors++; $display("FAIL midrst_next got %0d/%h exp 2/33", grant_id, tx_data);
    end
    req_valid = '0;
    finish_frame(3, stray);
  endtask

  task automatic test_timeout;
    int cyc;
    req_valid = 4'b0001;
    wait_load(10, cyc);
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL to_setup got %0d exp 0", grant_id); end
    req_valid = 4'b1010;
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int at;
      int stray;
      at    = -1;
      stray = 0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (req_ready != '0) stray++;
        if (timeout_err) begin
          at = i;
          break;
        end
      end
      // 16 full WAIT_START cycles (i = 1..16), pulse visible in the next one.
      checks++; if (at !== 17) begin errors++; $display("FAIL to_pulse_time got %0d exp 17", at); end
      checks++; if (arb_busy !== 1'b0 || stray !== 0) begin
        errors++; $display("FAIL to_idle got arb_busy=%b stray=%0d exp 0/0", arb_busy, stray);
      end
      tick();
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_single_pulse got %b exp 0", timeout_err); end
      checks++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
        errors++; $display("FAIL to_next_grant got %0d/%b exp 1/0010", grant_id, req_ready);
      end
      req_valid = '0;
      finish_frame(3, stray);
    end
`else
    begin
      int viol;
      viol = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (arb_busy !== 1'b1 || timeout_err !== 1'b0 || req_ready != '0) viol++;
      end
      checks++; if (viol !== 0) begin errors++; $display("FAIL to_disabled_wait got %0d bad cycles exp 0", viol); end
      do_reset();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_busy_hold();
    test_reset_mid_frame();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one UART transmitter among NUM_REQ byte requesters, such as APB write path, status/echo channel and debug port.
- Grants one requester per frame and captures its byte.
- Issues a single-cycle data_valid to the transmitter FSM, then holds off further grants until the transmitter's busy has risen and fallen again (frame complete).
- Sits between the requesters and the transmitter FSM + serializer in the UCLK domain.

Parameters:
- NUM_REQ, 4, number of requesters (>= 2).
- DATA_WIDTH, 8, byte width sent per frame.
- TIMEOUT_CYCLES, 16, cycles to wait for tx_busy to rise after issue (used only with UART_TX_ARB_TIMEOUT_EN).

Ports:
- UCLK  in  1  UART-divided clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte-pending flag.
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot, single-cycle pulse: byte of requester i accepted.
- tx_busy  in  1  transmitter busy flag.
- tx_data_valid  out  1  single-cycle start request to transmitter.
- tx_data  out  DATA_WIDTH  captured byte to serializer; stable from issue until next capture.
- grant_id  out  clog2(NUM_REQ)  index of last granted requester.
- arb_busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  single-cycle error pulse (tied 0 without the macro).

Behaviour:
- Reset values: state IDLE, req_ready 0, tx_data_valid 0, tx_data 0, grant_id 0, arb_busy 0, timeout_err 0, rr pointer NUM_REQ-1 (requester 0 has first priority). Reset mid-frame aborts to IDLE; no ready pulse for an uncaptured byte.
- IDLE:
  - If any req_valid and tx_busy==0: winner = first asserted index searching pointer+1, pointer+2, ... modulo NUM_REQ.
  - At the edge, capture req_data[winner] into tx_data and winner into grant_id, then go to LOAD.
  - If tx_busy==1 (transmitter busy externally), no grant.
- LOAD (1 cycle):
  - tx_data_valid=1, req_ready[grant_id]=1, rr pointer <= grant_id.
  - Go to WAIT_START.
- WAIT_START:
  - tx_data_valid=0.
  - tx_busy==1 -> WAIT_DONE; otherwise stay.
- WAIT_DONE:
  - tx_busy==0 -> IDLE; otherwise stay.
- Latency:
  - req_valid high at edge k (in IDLE, tx_busy low) -> req_ready and tx_data_valid high during cycle k+1.
  - tx_busy is normally seen in cycle k+2.
- Minimum gap: one IDLE cycle between tx_busy falling and the next LOAD.
- Requesters hold valid/data until ready. A valid dropped after the capture edge is ignored; the captured byte is still sent.
- Valids changing during WAIT_START/WAIT_DONE have no effect until IDLE.
- Pointer wrap-around: the requester after NUM_REQ-1 is 0.
- A single persistent requester is re-granted every frame.
- Exactly one req_ready bit is high per grant; none outside LOAD.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With macro defined:
  - Counter cleared on entry to WAIT_START, incremented each WAIT_START cycle.
  - If tx_busy is still 0 after TIMEOUT_CYCLES cycles: go to IDLE and pulse timeout_err for 1 cycle.
  - The byte is dropped and the pointer stays advanced.
  - Counter resets to 0.
- Without macro: WAIT_START waits indefinitely; timeout_err is constant 0 and no counter is instantiated.

Test Plan:
1. Reset, then req_valid=4'b0001 with req_data[7:0]=8'hA5, tx_busy rising 1 cycle after issue and held 11 cycles -> req_ready=0001 and tx_data_valid for exactly 1 cycle, tx_data=A5, grant_id=0, arb_busy low 1 cycle after tx_busy falls.
2. req_valid=4'b1111 held continuously, bytes 11/22/33/44 -> grant order 0,1,2,3,0; each req_ready pulse aligned with tx_data_valid; never two grants within one busy window.
3. Pointer at 2 (last grant 2), req_valid=4'b0011 -> next grant 0, then 1 (wrap-around).
4. tx_busy forced 1 while in IDLE with req_valid=4'b0100 -> no req_ready/tx_data_valid until tx_busy falls; grant 2 the cycle after.
5. reset asserted during WAIT_DONE -> next cycle all outputs at reset values; pending requester re-granted after reset release as requester 0-first order dictates.
6. (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) tx_busy held 0 after issue -> timeout_err pulses exactly once, 16 cycles after entering WAIT_START; back in IDLE; next valid requester granted. Without macro -> arb_busy stays 1, timeout_err stays 0.
